regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port between two requesters: the in-order pipeline writeback and a long-latency unit (divider/memory return).
- Long-latency results are buffered in a small FIFO and drained on cycles when the pipeline does not write.
- A starvation counter forces a pipeline stall slot so buffered results always drain.
- A combinational scoreboard query tells the hazard logic whether a register still has a buffered write pending.

---
 rtl/regfile_write_arbiter_if.sv | 40 ++++
 rtl/regfile_write_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of signals between the register-file write arbiter and its neighbours:
// pipeline writeback, long-latency unit, hazard query and the register-file write port.
interface regfile_write_arbiter_if;
  logic        pipe_valid;
  logic [4:0]  pipe_address;
  logic [31:0] pipe_data;
  logic        pipe_stall;

  logic        unit_valid;
  logic        unit_ready;
  logic [4:0]  unit_address;
  logic [31:0] unit_data;

  logic [4:0]  query_address;
  logic        query_pending;

  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] write_data;

  logic        protocol_error;

  // Handshake: a long-latency result transfers on a posedge where
  // unit_valid && unit_ready; unit_ready depends only on registered fill level.
  modport master (
    output pipe_valid, pipe_address, pipe_data,
    output unit_valid, unit_address, unit_data,
    output query_address,
    input  pipe_stall, unit_ready, query_pending,
    input  write_enable, write_address, write_data, protocol_error
  );

  modport slave (
    input  pipe_valid, pipe_address, pipe_data,
    input  unit_valid, unit_address, unit_data,
    input  query_address,
    output pipe_stall, unit_ready, query_pending,
    output write_enable, write_address, write_data, protocol_error
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares one register-file write port between pipeline writeback and a buffered
// long-latency unit; a starvation counter forces a drain slot.
module regfile_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic                   clock,
  input logic                   reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    addr_q  [DEPTH];
  logic [4:0]    addr_d  [DEPTH];
  logic [31:0]   data_q  [DEPTH];
  logic [31:0]   data_d  [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [SW-1:0] starve_inc;
  logic          pipe_stall_q, pipe_stall_d;
  logic          we_q, we_d;
  logic [4:0]    wa_q, wa_d;
  logic [31:0]   wd_q, wd_d;
  logic          perr_q, perr_d;

  logic empty, unit_ready, push, pipe_sel, pop, pending;

  always_comb begin
    empty      = (count_q == '0);
    unit_ready = (count_q != CW'(DEPTH));
    // Address-0 results are accepted on the handshake but never stored.
    push       = bus.unit_valid && unit_ready && (bus.unit_address != 5'd0);
    pipe_sel   = bus.pipe_valid && (bus.pipe_address != 5'd0);
    // During a stall slot the pipeline should be silent, so the head drains;
    // if it misbehaves it still wins and the error flag records it.
    pop        = !pipe_sel && !empty;

    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    we_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;

    if (pipe_sel) begin
      we_d = 1'b1;
      wa_d = bus.pipe_address;
      wd_d = bus.pipe_data;
    end else if (pop) begin
      we_d = 1'b1;
      wa_d = addr_q[rd_ptr_q];
      wd_d = data_q[rd_ptr_q];
    end

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push) begin
      addr_d[wr_ptr_q]  = bus.unit_address;
      data_d[wr_ptr_q]  = bus.unit_data;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);

    starve_inc   = starve_q + SW'(1);
    pipe_stall_d = 1'b0;
    starve_d     = '0;
    if (!empty && !pop) begin
      if (starve_inc == SW'(STARVE_LIMIT)) pipe_stall_d = 1'b1;
      else                                  starve_d     = starve_inc;
    end

    perr_d = perr_q || (bus.pipe_valid && pipe_stall_q);

    pending = 1'b0;
    if (bus.query_address != 5'd0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (addr_q[i] == bus.query_address)) pending = 1'b1;
      end
      if (we_q && (wa_q == bus.query_address)) pending = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      pipe_stall_q <= 1'b0;
      we_q         <= 1'b0;
      wa_q         <= '0;
      wd_q         <= '0;
      perr_q       <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      pipe_stall_q <= pipe_stall_d;
      we_q         <= we_d;
      wa_q         <= wa_d;
      wd_q         <= wd_d;
      perr_q       <= perr_d;
    end
  end

  assign bus.unit_ready     = unit_ready;
  assign bus.pipe_stall     = pipe_stall_q;
  assign bus.query_pending  = pending;
  assign bus.write_enable   = we_q;
  assign bus.write_address  = wa_q;
  assign bus.write_data     = wd_q;
  assign bus.protocol_error = perr_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: hand-computed expectations for
// reset, priority, full FIFO, starvation, address 0 and the pending query.
module tb_regfile_write_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_pipe(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.pipe_valid   = v;
    bus.pipe_address = a;
    bus.pipe_data    = d;
  endtask

  task automatic set_unit(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.unit_valid   = v;
    bus.unit_address = a;
    bus.unit_data    = d;
  endtask

  task automatic check_write(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_we"}, {31'd0, bus.write_enable}, 32'd1);
    check({tag, "_wa"}, {27'd0, bus.write_address}, {27'd0, a});
    check({tag, "_wd"}, bus.write_data, d);
  endtask

  initial begin
    logic [4:0] exp_addr [5];
    exp_addr = '{5'd16, 5'd17, 5'd18, 5'd19, 5'd20};
    set_pipe(1'b0, 5'd0, 32'd0);
    set_unit(1'b1, 5'd5, 32'h1234);
    bus.query_address = 5'd0;

    // Reset held two cycles with a unit offer present.
    tick();
    tick();
    check("rst_we",    {31'd0, bus.write_enable},   32'd0);
    check("rst_wa",    {27'd0, bus.write_address},  32'd0);
    check("rst_wd",    bus.write_data,              32'd0);
    check("rst_stall", {31'd0, bus.pipe_stall},     32'd0);
    check("rst_perr",  {31'd0, bus.protocol_error}, 32'd0);
    check("rst_ready", {31'd0, bus.unit_ready},     32'd1);
    reset = 1'b0;
    set_unit(1'b0, 5'd0, 32'd0);
    tick();
    check("post_rst_we", {31'd0, bus.write_enable}, 32'd0);

    // Pipeline priority over a buffered result.
    set_unit(1'b1, 5'd5, 32'hAAAA0005);
    set_pipe(1'b1, 5'd3, 32'h3);
    tick();
    check_write("prio_r3", 5'd3, 32'h3);
    set_unit(1'b0, 5'd0, 32'd0);
    set_pipe(1'b1, 5'd4, 32'h4);
    tick();
    check_write("prio_r4", 5'd4, 32'h4);
    set_pipe(1'b0, 5'd0, 32'd0);
    tick();
    check_write("prio_r5", 5'd5, 32'hAAAA0005);
    tick();
    check("idle_we", {31'd0, bus.write_enable}, 32'd0);
    check("idle_wa_hold", {27'd0, bus.write_address}, 32'd5);

    // Fill the FIFO while the pipeline keeps the port busy.
    for (int i = 0; i < 4; i++) begin
      set_unit(1'b1, 5'(16 + i), 32'h100 + 32'(i));
      set_pipe(1'b1, 5'(10 + i), 32'(i));
      tick();
      check_write("full_pipe", 5'(10 + i), 32'(i));
    end
    check("full_ready0", {31'd0, bus.unit_ready}, 32'd0);
    set_unit(1'b1, 5'd20, 32'h105);
    tick();
    check("full_ready_hold", {31'd0, bus.unit_ready}, 32'd0);
    set_pipe(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_write("drain", exp_addr[i], (i == 4) ? 32'h105 : 32'h100 + 32'(i));
      if (i == 0) check("drain_ready1", {31'd0, bus.unit_ready}, 32'd1);
      if (i == 1) set_unit(1'b0, 5'd0, 32'd0);
      check("drain_stall", {31'd0, bus.pipe_stall}, 32'd0);
    end
    tick();
    check("drain_done_we", {31'd0, bus.write_enable}, 32'd0);

    // Starvation: one entry, pipeline hogging the port.
    set_unit(1'b1, 5'd9, 32'h99);
    set_pipe(1'b1, 5'd1, 32'h11);
    tick();
    set_unit(1'b0, 5'd0, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("starve_stall_%0d", i), {31'd0, bus.pipe_stall}, (i == 8) ? 32'd1 : 32'd0);
    end
    set_pipe(1'b0, 5'd0, 32'd0);
    tick();
    check_write("forced_drain", 5'd9, 32'h99);
    check("stall_one_cycle", {31'd0, bus.pipe_stall}, 32'd0);
    check("perr_clean", {31'd0, bus.protocol_error}, 32'd0);

    // Same again, but the pipeline ignores the stall.
    set_unit(1'b1, 5'd9, 32'h98);
    set_pipe(1'b1, 5'd1, 32'h11);
    tick();
    set_unit(1'b0, 5'd0, 32'd0);
    repeat (8) tick();
    check("starve2_stall", {31'd0, bus.pipe_stall}, 32'd1);
    set_pipe(1'b1, 5'd2, 32'h22);
    tick();
    check_write("stall_violate", 5'd2, 32'h22);
    check("perr_set", {31'd0, bus.protocol_error}, 32'd1);
    set_pipe(1'b0, 5'd0, 32'd0);
    tick();
    check_write("late_drain", 5'd9, 32'h98);
    check("perr_sticky", {31'd0, bus.protocol_error}, 32'd1);

    // Reset mid-operation discards a buffered entry.
    set_unit(1'b1, 5'd12, 32'hC);
    set_pipe(1'b1, 5'd1, 32'h11);
    tick();
    set_unit(1'b0, 5'd0, 32'd0);
    set_pipe(1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    tick();
    check("midrst_we",   {31'd0, bus.write_enable},   32'd0);
    check("midrst_wa",   {27'd0, bus.write_address},  32'd0);
    check("midrst_perr", {31'd0, bus.protocol_error}, 32'd0);
    reset = 1'b0;
    tick();
    check("midrst_after_we", {31'd0, bus.write_enable}, 32'd0);
    check("midrst_ready",    {31'd0, bus.unit_ready},   32'd1);

    // Address 0 on both sides; pipe r0 must not block the pop.
    set_unit(1'b1, 5'd6, 32'h66);
    set_pipe(1'b1, 5'd1, 32'h11);
    tick();
    set_unit(1'b1, 5'd0, 32'hDEAD);
    set_pipe(1'b1, 5'd0, 32'hBEEF);
    bus.query_address = 5'd0;
    #1;
    check("q0_pending", {31'd0, bus.query_pending}, 32'd0);
    tick();
    check_write("r0_no_block", 5'd6, 32'h66);
    set_unit(1'b0, 5'd0, 32'd0);
    set_pipe(1'b0, 5'd0, 32'd0);
    tick();
    check("r0_not_stored", {31'd0, bus.write_enable}, 32'd0);
    check("r0_ready",      {31'd0, bus.unit_ready},   32'd1);

    // Pending query for r7 while queued, on the write stage, then gone.
    set_unit(1'b1, 5'd7, 32'h77);
    set_pipe(1'b1, 5'd1, 32'h11);
    tick();
    set_unit(1'b0, 5'd0, 32'd0);
    set_pipe(1'b0, 5'd0, 32'd0);
    for (int s = 0; s < 3; s++) begin
      bus.query_address = 5'd7;
      #1;
      check($sformatf("q7_stage%0d", s), {31'd0, bus.query_pending}, (s < 2) ? 32'd1 : 32'd0);
      bus.query_address = 5'd8;
      #1;
      check($sformatf("q8_stage%0d", s), {31'd0, bus.query_pending}, 32'd0);
      if (s == 0) begin
        tick();
        check_write("q_drain", 5'd7, 32'h77);
      end else if (s == 1) begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
